// File: rtl/ddr2_sys_ddr2_dmaster_b2p.sv
// Bytes-to-packets decoder: turns the escaped byte stream into a registered Avalon-ST packet stream.
// Optional channel decode is enabled by defining DDR2_DMASTER_B2P_CHANNEL_EN.
module ddr2_sys_ddr2_dmaster_b2p (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_startofpacket,
  output logic       out_endofpacket,
  output logic [7:0] out_channel,
  input  logic       out_ready
);

  localparam logic [7:0] SOP_C   = 8'h7A;
  localparam logic [7:0] EOP_C   = 8'h7B;
  localparam logic [7:0] CHAN_C  = 8'h7C;
  localparam logic [7:0] ESC_C   = 8'h7D;
  localparam logic [7:0] ESC_XOR = 8'h20;

  typedef enum logic [1:0] {
    ST_DATA,
    ST_ESC,
    ST_CHAN,
    ST_CHAN_ESC
  } state_t;

  state_t     state_q, state_d;
  logic       sop_pend_q, sop_pend_d;
  logic       eop_pend_q, eop_pend_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_sop_q, out_sop_d;
  logic       out_eop_q, out_eop_d;
  logic       accept;
  logic       emit;
  logic [7:0] emit_byte;
`ifdef DDR2_DMASTER_B2P_CHANNEL_EN
  logic [7:0] chan_q, chan_d;
  logic [7:0] out_channel_q, out_channel_d;
`endif

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Decode: every state change happens only on an accepted byte.
  always_comb begin
    state_d    = state_q;
    sop_pend_d = sop_pend_q;
    eop_pend_d = eop_pend_q;
    emit       = 1'b0;
    emit_byte  = in_data;
`ifdef DDR2_DMASTER_B2P_CHANNEL_EN
    chan_d     = chan_q;
`endif
    if (accept) begin
      case (state_q)
        ST_DATA: begin
          case (in_data)
            SOP_C:   sop_pend_d = 1'b1;
            EOP_C:   eop_pend_d = 1'b1;
            CHAN_C:  state_d    = ST_CHAN;
            ESC_C:   state_d    = ST_ESC;
            default: emit       = 1'b1;
          endcase
        end
        ST_ESC: begin
          emit      = 1'b1;
          emit_byte = in_data ^ ESC_XOR;
          state_d   = ST_DATA;
        end
        ST_CHAN: begin
          // Control characters other than ESC are literal channel numbers here.
          if (in_data == ESC_C) begin
            state_d = ST_CHAN_ESC;
          end else begin
            state_d = ST_DATA;
`ifdef DDR2_DMASTER_B2P_CHANNEL_EN
            chan_d  = in_data;
`endif
          end
        end
        ST_CHAN_ESC: begin
          state_d = ST_DATA;
`ifdef DDR2_DMASTER_B2P_CHANNEL_EN
          chan_d  = in_data ^ ESC_XOR;
`endif
        end
        default: state_d = ST_DATA;
      endcase
    end
    if (emit) begin
      sop_pend_d = 1'b0;
      eop_pend_d = 1'b0;
    end
  end

  // Output register: drains on out_ready, reloads in the same cycle on a new data byte.
  always_comb begin
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
`ifdef DDR2_DMASTER_B2P_CHANNEL_EN
    out_channel_d = out_channel_q;
`endif
    if (emit) begin
      out_valid_d = 1'b1;
      out_data_d  = emit_byte;
      out_sop_d   = sop_pend_q;
      out_eop_d   = eop_pend_q;
`ifdef DDR2_DMASTER_B2P_CHANNEL_EN
      out_channel_d = chan_q;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_DATA;
      sop_pend_q  <= 1'b0;
      eop_pend_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sop_pend_q  <= sop_pend_d;
      eop_pend_q  <= eop_pend_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
    end
  end

`ifdef DDR2_DMASTER_B2P_CHANNEL_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chan_q        <= 8'h00;
      out_channel_q <= 8'h00;
    end else begin
      chan_q        <= chan_d;
      out_channel_q <= out_channel_d;
    end
  end

  assign out_channel = out_channel_q;
`else
  assign out_channel = 8'h00;
`endif

  assign out_valid         = out_valid_q;
  assign out_data          = out_data_q;
  assign out_startofpacket = out_sop_q;
  assign out_endofpacket   = out_eop_q;

endmodule

// File: tb/tb_ddr2_sys_ddr2_dmaster_b2p.sv
// Directed bench for the bytes-to-packets decoder; outputs are sampled 1ns after each rising edge.
module tb_ddr2_sys_ddr2_dmaster_b2p;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_startofpacket;
  logic       out_endofpacket;
  logic [7:0] out_channel;
  logic       out_ready;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef DDR2_DMASTER_B2P_CHANNEL_EN
  localparam logic [7:0] CH_A = 8'h05;
  localparam logic [7:0] CH_B = 8'h7C;
`else
  localparam logic [7:0] CH_A = 8'h00;
  localparam logic [7:0] CH_B = 8'h00;
`endif

  ddr2_sys_ddr2_dmaster_b2p dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_ready          (in_ready),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .out_channel       (out_channel),
    .out_ready         (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, out_data, out_startofpacket, out_endofpacket, out_channel} !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b d=%h s=%b e=%b c=%h, want all zero",
               out_valid, out_data, out_startofpacket, out_endofpacket, out_channel);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    push(8'h7A);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_sop_no_out: got v=%b want 0", out_valid); end
    push(8'h01);
    n_checks++;
    if ({out_valid, out_data, out_startofpacket, out_endofpacket, out_channel} !== {1'b1, 8'h01, 1'b1, 1'b0, 8'h00}) begin
      n_fail++; $display("FAIL basic_b01: got v=%b d=%h s=%b e=%b c=%h want 1 01 1 0 00",
                         out_valid, out_data, out_startofpacket, out_endofpacket, out_channel);
    end
    push(8'h02);
    n_checks++;
    if ({out_valid, out_data, out_startofpacket, out_endofpacket} !== {1'b1, 8'h02, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL basic_b02: got v=%b d=%h s=%b e=%b want 1 02 0 0",
                         out_valid, out_data, out_startofpacket, out_endofpacket);
    end
    push(8'h7B);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_eop_no_out: got v=%b want 0", out_valid); end
    push(8'h03);
    n_checks++;
    if ({out_valid, out_data, out_startofpacket, out_endofpacket} !== {1'b1, 8'h03, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL basic_b03: got v=%b d=%h s=%b e=%b want 1 03 0 1",
                         out_valid, out_data, out_startofpacket, out_endofpacket);
    end
    idle();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got v=%b want 0", out_valid); end
  endtask

  task automatic test_escape();
    out_ready = 1'b1;
    push(8'h7A); push(8'h7D);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL esc_prefix_no_out: got v=%b want 0", out_valid); end
    push(8'h5A);
    n_checks++;
    if ({out_valid, out_data, out_startofpacket, out_endofpacket} !== {1'b1, 8'h7A, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL esc_7a: got v=%b d=%h s=%b e=%b want 1 7a 1 0",
                         out_valid, out_data, out_startofpacket, out_endofpacket);
    end
    push(8'h7D); push(8'h5D);
    n_checks++;
    if ({out_valid, out_data, out_startofpacket, out_endofpacket} !== {1'b1, 8'h7D, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL esc_7d: got v=%b d=%h s=%b e=%b want 1 7d 0 0",
                         out_valid, out_data, out_startofpacket, out_endofpacket);
    end
    push(8'h7B); push(8'h7D); push(8'h5B);
    n_checks++;
    if ({out_valid, out_data, out_startofpacket, out_endofpacket} !== {1'b1, 8'h7B, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL esc_7b: got v=%b d=%h s=%b e=%b want 1 7b 0 1",
                         out_valid, out_data, out_startofpacket, out_endofpacket);
    end
    idle();
  endtask

  task automatic test_channel();
    out_ready = 1'b1;
    push(8'h7C); push(8'h05); push(8'h7A);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL chan_ctrl_no_out: got v=%b want 0", out_valid); end
    push(8'h11);
    n_checks++;
    if ({out_valid, out_data, out_startofpacket, out_endofpacket, out_channel} !== {1'b1, 8'h11, 1'b1, 1'b0, CH_A}) begin
      n_fail++; $display("FAIL chan_b11: got v=%b d=%h s=%b e=%b c=%h want 1 11 1 0 %h",
                         out_valid, out_data, out_startofpacket, out_endofpacket, out_channel, CH_A);
    end
    push(8'h7C); push(8'h7D); push(8'h5C); push(8'h7B);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL chan_esc_no_out: got v=%b want 0", out_valid); end
    push(8'h22);
    n_checks++;
    if ({out_valid, out_data, out_startofpacket, out_endofpacket, out_channel} !== {1'b1, 8'h22, 1'b0, 1'b1, CH_B}) begin
      n_fail++; $display("FAIL chan_b22: got v=%b d=%h s=%b e=%b c=%h want 1 22 0 1 %h",
                         out_valid, out_data, out_startofpacket, out_endofpacket, out_channel, CH_B);
    end
    push(8'h44);
    n_checks++;
    if ({out_valid, out_data, out_startofpacket, out_endofpacket, out_channel} !== {1'b1, 8'h44, 1'b0, 1'b0, CH_B}) begin
      n_fail++; $display("FAIL chan_held: got v=%b d=%h s=%b e=%b c=%h want 1 44 0 0 %h",
                         out_valid, out_data, out_startofpacket, out_endofpacket, out_channel, CH_B);
    end
    push(8'h7C); push(8'h7A); push(8'h55);
    n_checks++;
    if ({out_valid, out_data, out_startofpacket} !== {1'b1, 8'h55, 1'b0}) begin
      n_fail++; $display("FAIL chan_literal_7a: got v=%b d=%h s=%b want 1 55 0",
                         out_valid, out_data, out_startofpacket);
    end
    idle();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    push(8'h7A);
    push(8'hAA);
    n_checks++;
    if ({out_valid, out_data, out_startofpacket, in_ready} !== {1'b1, 8'hAA, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL bp_hold_aa: got v=%b d=%h s=%b rdy=%b want 1 aa 1 0",
                         out_valid, out_data, out_startofpacket, in_ready);
    end
    push(8'hBB);
    push(8'hBB);
    n_checks++;
    if ({out_valid, out_data, out_startofpacket, out_endofpacket, in_ready} !== {1'b1, 8'hAA, 1'b1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL bp_stall: got v=%b d=%h s=%b e=%b rdy=%b want 1 aa 1 0 0",
                         out_valid, out_data, out_startofpacket, out_endofpacket, in_ready);
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_comb: got %b want 1", in_ready); end
    @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, out_data, out_startofpacket} !== {1'b1, 8'hBB, 1'b0}) begin
      n_fail++; $display("FAIL bp_bb_follow: got v=%b d=%h s=%b want 1 bb 0",
                         out_valid, out_data, out_startofpacket);
    end
    idle();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup: got v=%b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    push(8'h7A); push(8'h7B); push(8'h09);
    n_checks++;
    if ({out_valid, out_data, out_startofpacket, out_endofpacket} !== {1'b1, 8'h09, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL b2b_single: got v=%b d=%h s=%b e=%b want 1 09 1 1",
                         out_valid, out_data, out_startofpacket, out_endofpacket);
    end
    push(8'h0A);
    n_checks++;
    if ({out_valid, out_data, out_startofpacket, out_endofpacket} !== {1'b1, 8'h0A, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL b2b_next: got v=%b d=%h s=%b e=%b want 1 0a 0 0",
                         out_valid, out_data, out_startofpacket, out_endofpacket);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    push(8'h7D);
    in_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    push(8'h7A);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_esc_cleared: got v=%b d=%h want v=0", out_valid, out_data);
    end
    push(8'h33);
    n_checks++;
    if ({out_valid, out_data, out_startofpacket} !== {1'b1, 8'h33, 1'b1}) begin
      n_fail++; $display("FAIL rst_b33: got v=%b d=%h s=%b want 1 33 1", out_valid, out_data, out_startofpacket);
    end
    push(8'h7C);
    in_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    push(8'h66);
    n_checks++;
    if ({out_valid, out_data, out_channel} !== {1'b1, 8'h66, 8'h00}) begin
      n_fail++; $display("FAIL rst_chan_cleared: got v=%b d=%h c=%h want 1 66 00", out_valid, out_data, out_channel);
    end
    push(8'h7A); push(8'h7B);
    in_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    push(8'h44);
    n_checks++;
    if ({out_valid, out_data, out_startofpacket, out_endofpacket} !== {1'b1, 8'h44, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL rst_pend_cleared: got v=%b d=%h s=%b e=%b want 1 44 0 0",
                         out_valid, out_data, out_startofpacket, out_endofpacket);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_escape();
    test_channel();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
